// File: rtl/snoop_cache_node_if.sv
// snoop_cache_node_if: CPU request/response, shared-bus, snoop and flush signals of one cache node
interface snoop_cache_node_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              bus_req_valid;
  logic              bus_gnt;
  logic [1:0]        bus_cmd;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic [1:0]        bus_src;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rsp_data;
  logic              snoop_valid;
  logic [1:0]        snoop_cmd;
  logic [ADDR_W-1:0] snoop_addr;
  logic [1:0]        snoop_src;
  logic              flush_valid;
  logic [ADDR_W-1:0] flush_addr;
  logic [DATA_W-1:0] flush_data;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, bus_gnt, bus_rsp_valid, bus_rsp_data,
           snoop_valid, snoop_cmd, snoop_addr, snoop_src,
    output req_ready, rsp_valid, rsp_rdata, bus_req_valid, bus_cmd, bus_addr, bus_data, bus_src,
           flush_valid, flush_addr, flush_data
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, bus_gnt, bus_rsp_valid, bus_rsp_data,
           snoop_valid, snoop_cmd, snoop_addr, snoop_src,
    input  req_ready, rsp_valid, rsp_rdata, bus_req_valid, bus_cmd, bus_addr, bus_data, bus_src,
           flush_valid, flush_addr, flush_data
  );
endinterface

// File: rtl/snoop_cache_node.sv
// snoop_cache_node: direct-mapped MSI cache node serving one CPU and snooping a shared bus
module snoop_cache_node #(
  parameter int         ADDR_W  = 8,
  parameter int         DATA_W  = 8,
  parameter int         LINES   = 4,
  parameter logic [1:0] NODE_ID = 2'd0
) (
  input logic clock,
  input logic reset_n,
  snoop_cache_node_if.master io
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;
  localparam logic [1:0] C_WB = 2'd0, C_RM = 2'd1, C_WM = 2'd2, C_INV = 2'd3;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, MISS, INV, WAIT_RSP, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0]        st_q   [LINES];
  logic [1:0]        st_d   [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              flush_valid_q, flush_d;
  logic [ADDR_W-1:0] flush_addr_q;
  logic [DATA_W-1:0] flush_data_q;
  logic [IDX_W-1:0]  idx, sidx;
  logic [TAG_W-1:0]  tag, stag;
  logic [1:0]        sn_st;
  logic              hit, sn_hit, sn_chg, sn_here;
  always_comb begin
    idx     = addr_q[IDX_W-1:0];
    tag     = addr_q[ADDR_W-1:IDX_W];
    sidx    = io.snoop_addr[IDX_W-1:0];
    stag    = io.snoop_addr[ADDR_W-1:IDX_W];
    hit     = st_q[idx] != ST_I && tag_q[idx] == tag;
    sn_hit  = io.snoop_valid && io.snoop_src != NODE_ID && st_q[sidx] != ST_I && tag_q[sidx] == stag;
    flush_d = sn_hit && st_q[sidx] == ST_M && (io.snoop_cmd == C_RM || io.snoop_cmd == C_WM);
    sn_st   = (io.snoop_cmd == C_WM || (io.snoop_cmd == C_INV && st_q[sidx] == ST_S)) ? ST_I :
              flush_d ? ST_S : st_q[sidx];
    sn_chg  = sn_hit && sn_st != st_q[sidx];
    // a snoop altering the line we are working on preempts this cycle's decision
    sn_here = sn_chg && sidx == idx;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = io.req_valid ? LOOKUP : IDLE;
      LOOKUP:   state_d = sn_here ? LOOKUP :
                          hit ? ((!wr_q || st_q[idx] == ST_M) ? DONE : INV) :
                          (st_q[idx] == ST_M ? WB : MISS);
      WB:       state_d = io.bus_gnt ? MISS : WB;
      MISS:     state_d = io.bus_gnt ? WAIT_RSP : MISS;
      INV:      state_d = sn_here ? MISS : io.bus_gnt ? DONE : INV;
      WAIT_RSP: state_d = io.bus_rsp_valid ? DONE : WAIT_RSP;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    io.req_ready     = state_q == IDLE;
    io.rsp_valid     = state_q == DONE;
    io.rsp_rdata     = state_q == DONE ? data_q[idx] : '0;
    io.bus_req_valid = state_q inside {WB, MISS, INV};
    io.bus_cmd       = state_q == INV ? C_INV : state_q == MISS ? (wr_q ? C_WM : C_RM) : C_WB;
    io.bus_addr      = state_q == WB ? {tag_q[idx], idx} : state_q inside {MISS, INV} ? addr_q : '0;
    io.bus_data      = state_q == WB ? data_q[idx] : '0;
    io.bus_src       = NODE_ID;
    io.flush_valid   = flush_valid_q;
    io.flush_addr    = flush_addr_q;
    io.flush_data    = flush_data_q;
  end
  // snoop updates first; own-transaction updates on the same line take precedence after it
  always_comb begin
    st_d   = st_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (sn_chg) st_d[sidx] = sn_st;
    if (state_q == LOOKUP && !sn_here && hit && wr_q && st_q[idx] == ST_M) data_d[idx] = wdata_q;
    if (state_q == WB && io.bus_gnt) st_d[idx] = ST_I;
    if (state_q == INV && !sn_here && io.bus_gnt) begin
      st_d[idx]   = ST_M;
      data_d[idx] = wdata_q;
    end
    if (state_q == WAIT_RSP && io.bus_rsp_valid) begin
      st_d[idx]   = wr_q ? ST_M : ST_S;
      tag_d[idx]  = tag;
      data_d[idx] = wr_q ? wdata_q : io.bus_rsp_data;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) begin
        st_q[i]   <= ST_I;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      flush_valid_q <= 1'b0;
      flush_addr_q  <= '0;
      flush_data_q  <= '0;
    end else begin
      st_q          <= st_d;
      tag_q         <= tag_d;
      data_q        <= data_d;
      flush_valid_q <= flush_d;
      flush_addr_q  <= flush_d ? io.snoop_addr : '0;
      flush_data_q  <= flush_d ? data_q[sidx] : '0;
      if (state_q == IDLE && io.req_valid) begin
        wr_q    <= io.req_write;
        addr_q  <= io.req_addr;
        wdata_q <= io.req_wdata;
      end
    end
  end
endmodule
